// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_NUM_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done request-result bundle between a controller and the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
);

    logic                start;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                borrow_in;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] diff;
    logic                borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor cell: d = a - b - bin, bout set when the column underflows.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock behind a start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic               clk,
    input  logic               n_rst,
    serial_subtractor_if.slave bus
);

    localparam int              CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BITS - 1);

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] a_sr, b_sr, d_sr, diff_q;
    logic                br, borrow_q;
    logic [CNT_W-1:0]    count;
    logic                bit_d, bit_bout;
    logic                accept, last;

    full_subtractor_1bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // A new request is only taken when no operation is in flight.
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (state == SHIFT) && (count == LAST);

    // NOTE: flops use <= so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaulting first means every path assigns state_nxt, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift registers are ordinary flops, so they are reset too; an abort leaves no stale bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            br       <= 1'b0;
            count    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.borrow_in;
            count <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            d_sr  <= {bit_d, d_sr[NUM_BITS-1:1]};
            br    <= bit_bout;
            count <= count + 1'b1;
            // Results are published only here, so they stay stable until the next completion.
            if (last) begin
                diff_q   <= {bit_d, d_sr[NUM_BITS-1:1]};
                borrow_q <= bit_bout;
            end
        end
    end

    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor with hand-computed expected results.
module tb_serial_subtractor;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    serial_subtractor_if #(.NUM_BITS(N)) bus ();

    serial_subtractor #(.NUM_BITS(N)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int           busy_cnt, done_cnt, done_at, overlap;
    logic [N-1:0] res_d;
    logic         res_b;

    // One start pulse, then watch a fixed window: i=0 is the cycle right after the accepting edge.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.borrow_in = bin;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1; overlap = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at = i;
                res_d   = bus.diff;
                res_b   = bus.borrow_out;
            end
            if (bus.busy && bus.done) overlap++;
            @(negedge clk);
        end
    endtask

    int dc;
    int cases;
    int exp_d;
    int exp_b;

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.borrow_out, 0);
        n_rst = 1'b1;

        // 5 - 3
        do_op(4'd5, 4'd3, 1'b0);
        check("t1_busy_cycles", busy_cnt, 4);
        check("t1_done_count", done_cnt, 1);
        check("t1_done_at", done_at, 4);
        check("t1_overlap", overlap, 0);
        check("t1_diff", res_d, 4'h2);
        check("t1_bout", res_b, 0);

        do_op(4'd3, 4'd5, 1'b0);
        check("t2a_diff", res_d, 4'hE);
        check("t2a_bout", res_b, 1);
        do_op(4'd0, 4'd0, 1'b1);
        check("t2b_diff", res_d, 4'hF);
        check("t2b_bout", res_b, 1);
        check("t2b_done_count", done_cnt, 1);

        // Start held through SHIFT with changing operands, then a back-to-back request in DONE.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd4; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.a = 4'd15; bus.b = 4'd1; bus.borrow_in = 1'b1;
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dc++;
            if (i == 3) begin
                check("t3_no_early_done", dc, 0);
                bus.a = 4'd8; bus.b = 4'd8; bus.borrow_in = 1'b1;
            end
            if (i == 4) begin
                check("t3_done", bus.done, 1);
                check("t3_busy_in_done", bus.busy, 0);
                check("t3_diff", bus.diff, 4'h5);
                check("t3_bout", bus.borrow_out, 0);
            end
            if (i == 5) begin
                bus.start = 1'b0;
                check("t4_busy_again", bus.busy, 1);
                check("t4_done_gone", bus.done, 0);
            end
            if (i == 8) check("t4_first_held", bus.diff, 4'h5);
            if (i == 9) begin
                check("t4_done", bus.done, 1);
                check("t4_diff", bus.diff, 4'hF);
                check("t4_bout", bus.borrow_out, 1);
            end
            @(negedge clk);
        end
        check("t4_total_dones", dc, 2);

        // Reset two edges into SHIFT.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd2; bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_busy_pre", bus.busy, 1);
        check("t5_diff_pre", bus.diff, 4'hF);
        n_rst = 1'b0;
        #1;
        check("t5_busy", bus.busy, 0);
        check("t5_done", bus.done, 0);
        check("t5_diff", bus.diff, 0);
        check("t5_bout", bus.borrow_out, 0);
        dc = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        n_rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        check("t5_no_activity", dc, 0);
        do_op(4'd12, 4'd7, 1'b0);
        check("t5_after_diff", res_d, 4'h5);
        check("t5_after_bout", res_b, 0);
        check("t5_after_done_at", done_at, 4);

        cases = 0;
        for (int c = 0; c < 512; c++) begin
            do_op(c[3:0], c[7:4], c[8]);
            exp_d = (int'(c[3:0]) - int'(c[7:4]) - int'(c[8])) & 15;
            exp_b = (int'(c[3:0]) < int'(c[7:4]) + int'(c[8])) ? 1 : 0;
            check($sformatf("exh_diff a=%0d b=%0d bin=%0d", c[3:0], c[7:4], c[8]), res_d, exp_d);
            check($sformatf("exh_bout a=%0d b=%0d bin=%0d", c[3:0], c[7:4], c[8]), res_b, exp_b);
            check($sformatf("exh_done a=%0d b=%0d bin=%0d", c[3:0], c[7:4], c[8]), done_cnt, 1);
            cases++;
        end
        $display("exhaustive cases run: %0d of 512", cases);
        check("exh_cases", cases, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
